// File: rtl/csr_file_unit_pkg.sv
// Shared core types and CSR address map used by the CSR file and its neighbours.
package C;
    localparam int XLEN = 64;
    localparam int ID_W = 6;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] pc;
    } rob_entry_t;

    typedef enum logic [1:0] {
        CSR_READ = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MISA_VAL      = 64'h8000_0000_0014_1101;
    localparam logic [XLEN-1:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
    localparam logic [XLEN-1:0] MSTATUS_MPP   = 64'h0000_0000_0000_1800;

    // WARL shaping is applied once, when the value enters the pending buffer.
    function automatic logic [XLEN-1:0] legalize(input logic [11:0] addr, input logic [XLEN-1:0] v);
        case (addr)
            A_MSTATUS: legalize = (v & MSTATUS_WMASK) | MSTATUS_MPP;
            A_MTVEC:   legalize = {v[XLEN-1:2], 2'b00};
            A_MEPC:    legalize = {v[XLEN-1:1], 1'b0};
            default:   legalize = v;
        endcase
    endfunction
endpackage

// File: rtl/interfaces.sv
// Signal bundles shared between the CSR unit, branch queue and their bench.
interface csr_if;
    import C::*;
    logic            req_valid;
    logic [11:0]     req_addr;
    csr_op_t         req_op;
    logic [XLEN-1:0] req_wdata;
    logic [ID_W-1:0] req_id;
    logic [XLEN-1:0] rdata;
    logic            illegal;

    modport csr_file (input req_valid, req_addr, req_op, req_wdata, req_id,
                      output rdata, illegal);
    modport csr_fu   (output req_valid, req_addr, req_op, req_wdata, req_id,
                      input rdata, illegal);
endinterface

interface bq_push_if;
    import C::*;
    logic            valid;
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
endinterface

interface bq_pop_if;
    import C::*;
    logic            valid;
    logic [ID_W-1:0] id;
endinterface

// File: rtl/csr_file_unit.sv
// Machine-mode CSR file: combinational reads, one retire-gated pending write,
// and the cycle/instret counters.
module csr_file_unit
    import C::*;
(
    input  logic       clk,
    input  logic       rstn,
    csr_if.csr_file    csr_io,
    input  rob_entry_t retire_entry_i,
    input  logic       retire_entry_i_valid
);
    logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
    logic [XLEN-1:0] mcycle_q, minstret_q;
    logic [XLEN-1:0] mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d, mip_d;
    logic [XLEN-1:0] mcycle_d, minstret_d;
    logic            buf_vld_q, buf_vld_d;
    logic [11:0]     buf_addr_q, buf_addr_d;
    logic [XLEN-1:0] buf_val_q, buf_val_d;
    logic [ID_W-1:0] buf_id_q, buf_id_d;

    logic            commit, impl, ro, effective, illegal, load;
    logic [XLEN-1:0] rdata, wval;
    logic            unused_pc;

    assign unused_pc      = ^retire_entry_i.pc;
    assign csr_io.rdata   = rdata;
    assign csr_io.illegal = illegal;

    always_comb begin
        commit = retire_entry_i_valid && buf_vld_q && (retire_entry_i.id == buf_id_q);

        impl  = 1'b1;
        ro    = 1'b0;
        rdata = '0;
        case (csr_io.req_addr)
            A_MSTATUS:  rdata = mstatus_q;
            A_MIE:      rdata = mie_q;
            A_MTVEC:    rdata = mtvec_q;
            A_MSCRATCH: rdata = mscratch_q;
            A_MEPC:     rdata = mepc_q;
            A_MCAUSE:   rdata = mcause_q;
            A_MTVAL:    rdata = mtval_q;
            A_MIP:      rdata = mip_q;
            A_MCYCLE:   rdata = mcycle_q;
            A_MINSTRET: rdata = minstret_q;
            A_MISA:     begin rdata = MISA_VAL;   ro = 1'b1; end
            A_CYCLE:    begin rdata = mcycle_q;   ro = 1'b1; end
            A_INSTRET:  begin rdata = minstret_q; ro = 1'b1; end
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID: ro = 1'b1;
            default:    impl = 1'b0;
        endcase
        // Same-cycle retire of the buffered write is visible to the reader.
        if (commit && (buf_addr_q == csr_io.req_addr))
            rdata = buf_val_q;

        effective = (csr_io.req_op != CSR_READ) &&
                    !((csr_io.req_op != CSR_RW) && (csr_io.req_wdata == '0));
        illegal   = csr_io.req_valid && (!impl || (ro && effective));
        load      = csr_io.req_valid && effective && !illegal;

        case (csr_io.req_op)
            CSR_RS:  wval = rdata | csr_io.req_wdata;
            CSR_RC:  wval = rdata & ~csr_io.req_wdata;
            default: wval = csr_io.req_wdata;
        endcase

        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = mip_q;
        mcycle_d   = mcycle_q + 1'b1;
        minstret_d = minstret_q + {{(XLEN-1){1'b0}}, retire_entry_i_valid};
        if (commit) begin
            case (buf_addr_q)
                A_MSTATUS:  mstatus_d  = buf_val_q;
                A_MIE:      mie_d      = buf_val_q;
                A_MTVEC:    mtvec_d    = buf_val_q;
                A_MSCRATCH: mscratch_d = buf_val_q;
                A_MEPC:     mepc_d     = buf_val_q;
                A_MCAUSE:   mcause_d   = buf_val_q;
                A_MTVAL:    mtval_d    = buf_val_q;
                A_MIP:      mip_d      = buf_val_q;
                A_MCYCLE:   mcycle_d   = buf_val_q;
                A_MINSTRET: minstret_d = buf_val_q;
                default:    ;
            endcase
        end

        buf_vld_d  = buf_vld_q && !commit;
        buf_addr_d = buf_addr_q;
        buf_val_d  = buf_val_q;
        buf_id_d   = buf_id_q;
        if (load) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = csr_io.req_addr;
            buf_val_d  = legalize(csr_io.req_addr, wval);
            buf_id_d   = csr_io.req_id;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mstatus_q  <= MSTATUS_MPP;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_val_q  <= '0;
            buf_id_q   <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_val_q  <= buf_val_d;
            buf_id_q   <= buf_id_d;
        end
    end
endmodule

// File: tb/tb_csr_file_unit.sv
// Directed bench for csr_file_unit; expectations are queued by the stimulus
// and checked by an independent negedge monitor.
module tb_csr_file_unit;
    import C::*;

    typedef struct {
        string       name;
        logic [63:0] rd;
        logic        chk_rd;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    rob_entry_t ret_e;
    logic       ret_v;
    logic       chk_now;
    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;

    csr_if io();

    csr_file_unit dut (
        .clk                 (clk),
        .rstn                (rstn),
        .csr_io              (io),
        .retire_entry_i      (ret_e),
        .retire_entry_i_valid(ret_v)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_now) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: no expected entry queued", "monitor");
            end else begin
                e = exp_q.pop_front();
                if (io.illegal !== e.ill || (e.chk_rd && io.rdata !== e.rd)) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h illegal=%b, want rdata=%h illegal=%b",
                             e.name, io.rdata, io.illegal, e.rd, e.ill);
                end
            end
        end
    end

    // Runs from just after a posedge to just after the next one.
    task automatic step(input csr_op_t op, input logic [11:0] addr, input logic [63:0] wd,
                        input logic [5:0] id, input logic rv, input logic [5:0] rid,
                        input logic chk, input logic crd, input logic [63:0] erd,
                        input logic eill, input string nm);
        exp_t e;
        io.req_valid = 1'b1;
        io.req_op    = op;
        io.req_addr  = addr;
        io.req_wdata = wd;
        io.req_id    = id;
        ret_v        = rv;
        ret_e.id     = rid;
        ret_e.pc     = 64'h1000 + 64'(rid);
        chk_now      = chk;
        if (chk) begin
            e.name = nm; e.rd = erd; e.chk_rd = crd; e.ill = eill;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        io.req_valid = 1'b0;
        ret_v        = 1'b0;
        chk_now      = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] erd, input string nm);
        step(CSR_READ, a, 0, 0, 0, 0, 1, 1, erd, 0, nm);
    endtask

    task automatic rd_ret(input logic [11:0] a, input logic [5:0] rid, input logic [63:0] erd, input string nm);
        step(CSR_READ, a, 0, 0, 1, rid, 1, 1, erd, 0, nm);
    endtask

    task automatic wr(input csr_op_t op, input logic [11:0] a, input logic [63:0] wd, input logic [5:0] id);
        step(op, a, wd, id, 0, 0, 0, 0, 0, 0, "");
    endtask

    task automatic retire(input logic [5:0] rid);
        step(CSR_READ, 12'h300, 0, 0, 1, rid, 0, 0, 0, 0, "");
    endtask

    initial begin
        io.req_valid = 1'b0; io.req_op = CSR_READ; io.req_addr = '0;
        io.req_wdata = '0;   io.req_id = '0;
        ret_v = 1'b0; ret_e = '0; chk_now = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        rd(12'h300, 64'h1800, "rst_mstatus");
        rd(12'h301, 64'h8000_0000_0014_1101, "misa");
        rd(12'h305, 64'h0, "rst_mtvec");
        step(CSR_READ, 12'h7C0, 0, 0, 0, 0, 1, 0, 0, 1, "unimpl");

        step(CSR_RW, 12'h340, 64'hDEAD, 5, 0, 0, 1, 1, 64'h0, 0, "rw_old");
        rd(12'h340, 64'h0, "pre_retire");
        rd_ret(12'h340, 5, 64'hDEAD, "bypass");
        rd(12'h340, 64'hDEAD, "post_retire");

        wr(CSR_RW, 12'h340, 64'hF0, 1);
        retire(1);
        step(CSR_RS, 12'h340, 64'h0F, 2, 0, 0, 1, 1, 64'hF0, 0, "rs_old");
        rd_ret(12'h340, 2, 64'hFF, "rs_commit");
        step(CSR_RC, 12'h340, 64'h3C, 3, 0, 0, 1, 1, 64'hFF, 0, "rc_old");
        rd_ret(12'h340, 3, 64'hC3, "rc_commit");

        step(CSR_RS, 12'hF14, 64'h0, 4, 0, 0, 1, 1, 64'h0, 0, "rs0_ro");
        rd_ret(12'h340, 4, 64'hC3, "rs0_nowrite");
        step(CSR_RW, 12'hF14, 64'h1, 4, 0, 0, 1, 0, 0, 1, "rw_ro");
        rd_ret(12'hF14, 4, 64'h0, "ro_unchanged");
        step(CSR_RC, 12'h7C0, 64'h0, 0, 0, 0, 1, 0, 0, 1, "rc0_unimpl");

        wr(CSR_RW, 12'h305, 64'h8000_0003, 6);
        rd_ret(12'h305, 6, 64'h8000_0000, "mtvec");
        rd(12'h305, 64'h8000_0000, "mtvec_hold");
        wr(CSR_RW, 12'h300, '1, 8);
        retire(8);
        rd(12'h300, 64'h1888, "mstatus_warl");
        wr(CSR_RW, 12'h341, 64'h1235, 9);
        retire(9);
        rd(12'h341, 64'h1234, "mepc");

        wr(CSR_RW, 12'h342, 64'h77, 10);
        rd_ret(12'h342, 11, 64'h0, "wrong_id");
        rd_ret(12'h342, 10, 64'h77, "mcause");

        // Reset with a write outstanding; counters restart from zero.
        wr(CSR_RW, 12'h340, 64'h55, 12);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rd(12'hB00, 64'd10, "mcycle");
        rd(12'hC00, 64'd11, "cycle_alias");
        rd_ret(12'h340, 12, 64'h0, "rst_drop");
        retire(0);
        retire(0);
        rd(12'hB02, 64'd3, "minstret");
        rd(12'hC02, 64'd3, "instret");

        step(CSR_RW, 12'hB02, 64'd100, 7, 0, 0, 1, 1, 64'd3, 0, "minstret_old");
        rd_ret(12'hB02, 7, 64'd100, "minstret_bypass");
        rd(12'hB02, 64'd100, "minstret_commit");
        rd(12'hC02, 64'd100, "instret_commit");

        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
